// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing one memory bus between the CPU (port 0)
// and a DMA master (port 1); one transaction at a time with a fixed bus latency.
module mem_arbiter #(
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_valid,
  input  logic [15:0] req0_address,
  input  logic        req0_write_enable,
  input  logic [31:0] req0_write_data,
  input  logic [3:0]  req0_write_mask,
  output logic        req0_ready,
  output logic        req0_done,
  input  logic        req1_valid,
  input  logic [15:0] req1_address,
  input  logic        req1_write_enable,
  input  logic [31:0] req1_write_data,
  input  logic [3:0]  req1_write_mask,
  output logic        req1_ready,
  output logic        req1_done,
  output logic [31:0] read_data,
  output logic        busy,
  output logic        owner,
  output logic [15:0] mem_address,
  output logic [31:0] mem_write,
  output logic [3:0]  mem_write_mask,
  output logic        mem_bus_enable,
  output logic        mem_write_enable,
  input  logic [31:0] mem_read
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    COMPLETE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                last_grant_q, last_grant_d;
  logic                owner_q, owner_d;
  logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
  logic [DATA_W-1:0]   mem_write_q, mem_write_d;
  logic [MASK_W-1:0]   mem_write_mask_q, mem_write_mask_d;
  logic                mem_bus_enable_q, mem_bus_enable_d;
  logic                mem_write_enable_q, mem_write_enable_d;
  logic [DATA_W-1:0]   read_data_q, read_data_d;
  logic                req0_done_q, req0_done_d;
  logic                req1_done_q, req1_done_d;
  logic                winner_c;

  // Round robin on contention: the port that did not win last time goes first.
  always_comb begin
    if (req0_valid && req1_valid) begin
      winner_c = ~last_grant_q;
    end else begin
      winner_c = req1_valid;
    end
    req0_ready = (state_q == IDLE) & req0_valid & ~winner_c;
    req1_ready = (state_q == IDLE) & req1_valid &  winner_c;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d            = state_q;
    count_d            = count_q;
    last_grant_d       = last_grant_q;
    owner_d            = owner_q;
    mem_address_d      = mem_address_q;
    mem_write_d        = mem_write_q;
    mem_write_mask_d   = mem_write_mask_q;
    mem_bus_enable_d   = mem_bus_enable_q;
    mem_write_enable_d = mem_write_enable_q;
    read_data_d        = read_data_q;
    req0_done_d        = 1'b0;
    req1_done_d        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req0_ready || req1_ready) begin
          mem_address_d      = winner_c ? req1_address      : req0_address;
          mem_write_d        = winner_c ? req1_write_data   : req0_write_data;
          mem_write_mask_d   = winner_c ? req1_write_mask   : req0_write_mask;
          mem_write_enable_d = winner_c ? req1_write_enable : req0_write_enable;
          mem_bus_enable_d   = 1'b1;
          owner_d            = winner_c;
          last_grant_d       = winner_c;
          count_d            = CNT_W'(LATENCY - 1);
          state_d            = ACCESS;
        end
      end
      ACCESS: begin
        if (count_q != '0) begin
          count_d = count_q - CNT_W'(1);
        end else begin
          if (!mem_write_enable_q) begin
            read_data_d = mem_read;
          end
          mem_bus_enable_d   = 1'b0;
          mem_write_enable_d = 1'b0;
          req0_done_d        = ~owner_q;
          req1_done_d        =  owner_q;
          state_d            = COMPLETE;
        end
      end
      COMPLETE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q            <= IDLE;
      count_q            <= '0;
      last_grant_q       <= 1'b1;
      owner_q            <= 1'b0;
      mem_address_q      <= '0;
      mem_write_q        <= '0;
      mem_write_mask_q   <= '0;
      mem_bus_enable_q   <= 1'b0;
      mem_write_enable_q <= 1'b0;
      read_data_q        <= '0;
      req0_done_q        <= 1'b0;
      req1_done_q        <= 1'b0;
    end else begin
      state_q            <= state_d;
      count_q            <= count_d;
      last_grant_q       <= last_grant_d;
      owner_q            <= owner_d;
      mem_address_q      <= mem_address_d;
      mem_write_q        <= mem_write_d;
      mem_write_mask_q   <= mem_write_mask_d;
      mem_bus_enable_q   <= mem_bus_enable_d;
      mem_write_enable_q <= mem_write_enable_d;
      read_data_q        <= read_data_d;
      req0_done_q        <= req0_done_d;
      req1_done_q        <= req1_done_d;
    end
  end

  assign busy             = (state_q != IDLE);
  assign owner            = owner_q;
  assign read_data        = read_data_q;
  assign req0_done        = req0_done_q;
  assign req1_done        = req1_done_q;
  assign mem_address      = mem_address_q;
  assign mem_write        = mem_write_q;
  assign mem_write_mask   = mem_write_mask_q;
  assign mem_bus_enable   = mem_bus_enable_q;
  assign mem_write_enable = mem_write_enable_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (LATENCY 1 and 3) checked every cycle
// against a transaction-level model, plus directed literal expectations.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        v   [2][2];
  logic [15:0] a   [2][2];
  logic        we  [2][2];
  logic [31:0] wd  [2][2];
  logic [3:0]  wm  [2][2];
  logic [31:0] mrd [2];

  logic        rdy   [2][2];
  logic        dn    [2][2];
  logic [31:0] rdata [2];
  logic        bsy   [2];
  logic        own   [2];
  logic [15:0] maddr [2];
  logic [31:0] mwr   [2];
  logic [3:0]  mmask [2];
  logic        men   [2];
  logic        mwe   [2];

  genvar g;
  for (g = 0; g < 2; g++) begin : g_dut
    mem_arbiter #(.LATENCY(g == 0 ? 1 : 3)) u_dut (
      .clk(clk), .reset_n(reset_n),
      .req0_valid(v[g][0]), .req0_address(a[g][0]), .req0_write_enable(we[g][0]),
      .req0_write_data(wd[g][0]), .req0_write_mask(wm[g][0]),
      .req0_ready(rdy[g][0]), .req0_done(dn[g][0]),
      .req1_valid(v[g][1]), .req1_address(a[g][1]), .req1_write_enable(we[g][1]),
      .req1_write_data(wd[g][1]), .req1_write_mask(wm[g][1]),
      .req1_ready(rdy[g][1]), .req1_done(dn[g][1]),
      .read_data(rdata[g]), .busy(bsy[g]), .owner(own[g]),
      .mem_address(maddr[g]), .mem_write(mwr[g]), .mem_write_mask(mmask[g]),
      .mem_bus_enable(men[g]), .mem_write_enable(mwe[g]), .mem_read(mrd[g])
    );
  end

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // Transaction model: "since" counts edges since the accept edge (0 = idle).
  // Bus is driven for edges 1..L, done is the (L+1)th, then the block is idle.
  int          since  [2] = '{0, 0};
  logic        own_m  [2];
  logic        last_m [2];
  logic [15:0] addr_m [2];
  logic [31:0] wd_m   [2];
  logic [3:0]  wm_m   [2];
  logic        we_m   [2];
  logic [31:0] rd_m   [2];

  function automatic int win(input int k);
    if (v[k][0] && v[k][1]) return last_m[k] ? 0 : 1;
    if (v[k][1]) return 1;
    return 0;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 2; k++) begin
        since[k] <= 0; own_m[k] <= 1'b0; last_m[k] <= 1'b1;
        addr_m[k] <= '0; wd_m[k] <= '0; wm_m[k] <= '0; we_m[k] <= 1'b0; rd_m[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (since[k] == 0) begin
          if (v[k][0] || v[k][1]) begin
            since[k]  <= 1;
            own_m[k]  <= 1'(win(k));
            last_m[k] <= 1'(win(k));
            addr_m[k] <= a[k][win(k)];
            wd_m[k]   <= wd[k][win(k)];
            wm_m[k]   <= wm[k][win(k)];
            we_m[k]   <= we[k][win(k)];
          end
        end else if (since[k] == lat(k) + 1) begin
          since[k] <= 0;
        end else begin
          since[k] <= since[k] + 1;
          if (since[k] == lat(k) && !we_m[k]) rd_m[k] <= mrd[k];
        end
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 2; k++) begin
      logic ben;
      ben = (since[k] >= 1) && (since[k] <= lat(k));
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("L%0d.ready%0d", lat(k), p), 32'(rdy[k][p]),
            32'((since[k] == 0) && v[k][p] && (win(k) == p)));
        chk($sformatf("L%0d.done%0d", lat(k), p), 32'(dn[k][p]),
            32'((since[k] == lat(k) + 1) && (int'(own_m[k]) == p)));
      end
      chk($sformatf("L%0d.bus_enable", lat(k)), 32'(men[k]), 32'(ben));
      chk($sformatf("L%0d.write_enable", lat(k)), 32'(mwe[k]), 32'(ben && we_m[k]));
      chk($sformatf("L%0d.busy", lat(k)), 32'(bsy[k]), 32'(since[k] != 0));
      chk($sformatf("L%0d.owner", lat(k)), 32'(own[k]), 32'(own_m[k]));
      chk($sformatf("L%0d.address", lat(k)), 32'(maddr[k]), 32'(addr_m[k]));
      chk($sformatf("L%0d.wdata", lat(k)), mwr[k], wd_m[k]);
      chk($sformatf("L%0d.mask", lat(k)), 32'(mmask[k]), 32'(wm_m[k]));
      chk($sformatf("L%0d.read_data", lat(k)), rdata[k], rd_m[k]);
    end
  end

  // Present a request and hold it until accepted; scramble payload afterwards.
  task automatic request(input int k, input int p, input logic [15:0] addr,
                         input logic w, input logic [31:0] data, input logic [3:0] mask);
    bit got;
    got = 0;
    v[k][p] = 1'b1; a[k][p] = addr; we[k][p] = w; wd[k][p] = data; wm[k][p] = mask;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = rdy[k][p];
    end
    chk("request_accept_timeout", 32'(got), 32'd1);
    @(posedge clk); #1;
    v[k][p] = 1'b0; a[k][p] = 16'hFFFF; we[k][p] = ~w; wd[k][p] = 32'hFFFF_FFFF; wm[k][p] = 4'hF;
  endtask

  task automatic wait_done(input int k, input int p, output int ben_n, output int we_n);
    bit seen;
    seen = 0; ben_n = 0; we_n = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (men[k]) ben_n++;
      if (mwe[k]) we_n++;
      seen = dn[k][p];
    end
    chk("done_timeout", 32'(seen), 32'd1);
    @(posedge clk); #1;
  endtask

  int ben_n, we_n, n_acc, n_done, cnt;
  int grants[$];
  int t_acc[3];
  bit acc;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mrd[k] = '0;
      for (int p = 0; p < 2; p++) begin
        v[k][p] = 1'b0; a[k][p] = '0; we[k][p] = 1'b0; wd[k][p] = '0; wm[k][p] = '0;
      end
    end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    chk("reset_read_data", rdata[0], 32'h0);
    chk("reset_busy", 32'(bsy[0]), 32'h0);
    repeat (2) begin @(posedge clk); #1; end

    // Single read on the LATENCY=1 instance.
    mrd[0] = 32'h1234_5678;
    request(0, 0, 16'h4000, 1'b0, 32'h0, 4'h0);
    wait_done(0, 0, ben_n, we_n);
    chk("read_bus_enable_cycles", 32'(ben_n), 32'd1);
    chk("read_data_value", rdata[0], 32'h1234_5678);
    repeat (2) begin @(posedge clk); #1; end

    // Byte write from the DMA port; read_data must keep the previous read.
    mrd[0] = 32'hDEAD_BEEF;
    request(0, 1, 16'h8001, 1'b1, 32'h0000_00AB, 4'b1101);
    chk("write_mask_latched", 32'(mmask[0]), 32'hD);
    chk("write_address_latched", 32'(maddr[0]), 32'h8001);
    wait_done(0, 1, ben_n, we_n);
    chk("write_enable_cycles", 32'(we_n), 32'd1);
    chk("write_keeps_read_data", rdata[0], 32'h1234_5678);
    repeat (2) begin @(posedge clk); #1; end

    // Contention: both ports valid straight out of reset.
    reset_n = 1'b0;
    v[0][0] = 1'b1; a[0][0] = 16'h0100; we[0][0] = 1'b0;
    v[0][1] = 1'b1; a[0][1] = 16'h0200; we[0][1] = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    for (int i = 0; i < 100 && grants.size() < 6; i++) begin
      @(negedge clk);
      if (rdy[0][0]) grants.push_back(0);
      if (rdy[0][1]) grants.push_back(1);
      @(posedge clk); #1;
    end
    v[0][0] = 1'b0; v[0][1] = 1'b0;
    chk("grant_count", 32'(grants.size()), 32'd6);
    for (int i = 0; i < 6 && i < grants.size(); i++)
      chk($sformatf("grant_order[%0d]", i), 32'(grants[i]), 32'(i % 2));
    repeat (4) begin @(posedge clk); #1; end

    // Withdrawal: a one-cycle DMA request during a CPU access is never granted.
    cnt = 0;
    request(0, 0, 16'h1234, 1'b0, 32'h0, 4'h0);
    v[0][1] = 1'b1; a[0][1] = 16'h5555;
    @(negedge clk); if (rdy[0][1]) cnt++;
    @(posedge clk); #1 v[0][1] = 1'b0;
    repeat (8) begin @(negedge clk); if (rdy[0][1]) cnt++; end
    chk("withdrawn_never_granted", 32'(cnt), 32'd0);
    @(posedge clk); #1;

    // Latency sweep: back-to-back CPU reads on the LATENCY=3 instance.
    n_acc = 0; n_done = 0; ben_n = 0;
    mrd[1] = 32'hA5A5_0001;
    v[1][0] = 1'b1; a[1][0] = 16'h2000; we[1][0] = 1'b0;
    for (int i = 0; i < 80 && n_done < 3; i++) begin
      @(negedge clk);
      if (men[1]) ben_n++;
      if (dn[1][0]) n_done++;
      acc = rdy[1][0];
      if (acc && n_acc < 3) begin t_acc[n_acc] = cyc; n_acc++; end
      @(posedge clk); #1;
      if (acc) begin
        a[1][0] = a[1][0] + 16'h4;
        mrd[1] = mrd[1] + 32'h1;
        if (n_acc == 3) v[1][0] = 1'b0;
      end
    end
    chk("sweep_accepts", 32'(n_acc), 32'd3);
    chk("sweep_dones", 32'(n_done), 32'd3);
    chk("sweep_spacing_1", 32'(t_acc[1] - t_acc[0]), 32'd5);
    chk("sweep_spacing_2", 32'(t_acc[2] - t_acc[1]), 32'd5);
    chk("sweep_bus_enable_cycles", 32'(ben_n), 32'd9);
    chk("sweep_last_read", rdata[1], 32'hA5A5_0004);
    repeat (2) begin @(posedge clk); #1; end

    // Reset in the middle of an access aborts it without a done pulse.
    request(1, 1, 16'h3000, 1'b1, 32'hCAFE_F00D, 4'h3);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("abort_bus_enable", 32'(men[1]), 32'h0);
    chk("abort_write_enable", 32'(mwe[1]), 32'h0);
    chk("abort_busy", 32'(bsy[1]), 32'h0);
    chk("abort_owner", 32'(own[1]), 32'h0);
    chk("abort_address", 32'(maddr[1]), 32'h0);
    chk("abort_wdata", mwr[1], 32'h0);
    chk("abort_mask", 32'(mmask[1]), 32'h0);
    chk("abort_read_data", rdata[1], 32'h0);
    @(posedge clk); #1 reset_n = 1'b1;
    cnt = 0;
    repeat (8) begin @(negedge clk); if (dn[1][0] || dn[1][1]) cnt++; end
    chk("abort_no_done", 32'(cnt), 32'd0);
    repeat (2) begin @(posedge clk); #1; end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
